// File: rtl/counter_display_stage_if.sv
// Value bus between the counter stage and its display stage: the decoded value
// flows in, and the registered value, status flags and display drive flow out.
interface counter_display_stage_if;
  logic [3:0] I;
  logic [3:0] V;
  logic       CHG;
  logic       STUCK;
  logic [6:0] SEG;
  logic [1:0] AN;

  modport master (output I, input V, CHG, STUCK, SEG, AN);
  modport slave  (input I, output V, CHG, STUCK, SEG, AN);
endinterface

// File: rtl/counter_display_stage.sv
// Registers the counter value, flags changes and stalls, and scans it onto a
// two-digit multiplexed 7-segment display with the tens digit blanked below 10.
module counter_display_stage #(
  parameter int DIV   = 4,
  parameter int STALL = 3
) (
  input  logic                   C,
  input  logic                   R,
  counter_display_stage_if.slave bus
);

  localparam int SCW = $clog2(STALL + 1);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SCW-1:0] SC_MAX  = SCW'(STALL);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DIV - 1);

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  logic [SCW-1:0] sc;
  logic [SCW-1:0] sc_next;
  logic [DCW-1:0] dc;
  logic           ds;
  logic           tens;
  logic [3:0]     units;

  always_comb begin
    tens  = (bus.V >= 4'd10);
    units = tens ? (bus.V - 4'd10) : bus.V;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sc_next = '0;
    if (bus.I == bus.V) begin
      sc_next = (sc == SC_MAX) ? sc : sc + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // the output register relies on this to see V/DS from before the edge.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      bus.V     <= '0;
      bus.CHG   <= 1'b0;
      bus.STUCK <= 1'b0;
      sc        <= '0;
      dc        <= '0;
      ds        <= 1'b0;
      bus.SEG   <= '0;
      bus.AN    <= 2'b00;
    end else begin
      bus.V     <= bus.I;
      bus.CHG   <= (bus.I != bus.V);
      sc        <= sc_next;
      bus.STUCK <= (sc_next == SC_MAX);

      if (dc == DC_LAST) begin
        dc <= '0;
        ds <= ~ds;
      end else begin
        dc <= dc + 1'b1;
      end

      if (!ds) begin
        bus.AN  <= 2'b01;
        bus.SEG <= seg_code(units);
      end else if (tens) begin
        bus.AN  <= 2'b10;
        bus.SEG <= seg_code(4'd1);
      end else begin
        bus.AN  <= 2'b00;
        bus.SEG <= 7'h00;
      end
    end
  end

endmodule

// File: tb/tb_counter_display_stage.sv
// Drives two display stages (DIV=4 and DIV=1) with identical stimulus and
// compares every output against a cycle-count based reference model.
module tb_counter_display_stage;

  localparam int STALL = 3;
  localparam int DIVS [2] = '{4, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_display_stage_if bus0 ();
  counter_display_stage_if bus1 ();

  counter_display_stage #(.DIV(4), .STALL(STALL)) dut0 (.C(clk), .R(rst), .bus(bus0.slave));
  counter_display_stage #(.DIV(1), .STALL(STALL)) dut1 (.C(clk), .R(rst), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: last captured value, length of the current run of equal
  // samples, and the number of edges seen since reset release.
  int m_v   [2];
  int m_run [2];
  int m_k   [2];

  logic [3:0] o_v     [2];
  logic       o_chg   [2];
  logic       o_stuck [2];
  logic [6:0] o_seg   [2];
  logic [1:0] o_an    [2];

  task automatic sample();
    o_v[0] = bus0.V; o_chg[0] = bus0.CHG; o_stuck[0] = bus0.STUCK; o_seg[0] = bus0.SEG; o_an[0] = bus0.AN;
    o_v[1] = bus1.V; o_chg[1] = bus1.CHG; o_stuck[1] = bus1.STUCK; o_seg[1] = bus1.SEG; o_an[1] = bus1.AN;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_run[d] = 0; m_k[d] = 0;
    end
  endtask

  // Applies one value for one edge and compares all outputs with the model.
  task automatic drive_cycle(input string tag, input int val);
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_chg, e_stuck;
    int         digit_sel;
    bus0.I = 4'(val);
    bus1.I = 4'(val);
    @(posedge clk);
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      digit_sel = (m_k[d] / DIVS[d]) % 2;
      if (digit_sel == 0) begin
        e_an  = 2'b01;
        e_seg = seg_tab[m_v[d] % 10];
      end else if (m_v[d] >= 10) begin
        e_an  = 2'b10;
        e_seg = seg_tab[1];
      end else begin
        e_an  = 2'b00;
        e_seg = 7'h00;
      end
      e_chg    = (val != m_v[d]);
      m_run[d] = e_chg ? 0 : m_run[d] + 1;
      e_stuck  = (m_run[d] >= STALL);
      m_v[d]   = val;
      m_k[d]++;

      total += 5;
      if (o_v[d] !== 4'(val)) begin bad++; $display("FAIL %s dut%0d V got %0d want %0d", tag, d, o_v[d], val); end
      if (o_chg[d] !== e_chg) begin bad++; $display("FAIL %s dut%0d CHG got %b want %b", tag, d, o_chg[d], e_chg); end
      if (o_stuck[d] !== e_stuck) begin bad++; $display("FAIL %s dut%0d STUCK got %b want %b", tag, d, o_stuck[d], e_stuck); end
      if (o_seg[d] !== e_seg) begin bad++; $display("FAIL %s dut%0d SEG got %h want %h", tag, d, o_seg[d], e_seg); end
      if (o_an[d] !== e_an) begin bad++; $display("FAIL %s dut%0d AN got %b want %b", tag, d, o_an[d], e_an); end
    end
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      total += 5;
      if (o_seg[d] !== 7'h00) begin bad++; $display("FAIL %s dut%0d SEG got %h want 00", tag, d, o_seg[d]); end
      if (o_an[d] !== 2'b00) begin bad++; $display("FAIL %s dut%0d AN got %b want 00", tag, d, o_an[d]); end
      if (o_v[d] !== 4'd0) begin bad++; $display("FAIL %s dut%0d V got %0d want 0", tag, d, o_v[d]); end
      if (o_chg[d] !== 1'b0) begin bad++; $display("FAIL %s dut%0d CHG got %b want 0", tag, d, o_chg[d]); end
      if (o_stuck[d] !== 1'b0) begin bad++; $display("FAIL %s dut%0d STUCK got %b want 0", tag, d, o_stuck[d]); end
    end
    bus0.I = 4'd0;
    bus1.I = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    async_reset("reset");
  endtask

  task automatic test_value3();
    drive_cycle("val3_e1", 3);
    total += 2;
    if (bus0.V !== 4'd3) begin bad++; $display("FAIL val3 V got %0d want 3", bus0.V); end
    if (bus0.CHG !== 1'b1) begin bad++; $display("FAIL val3 CHG got %b want 1", bus0.CHG); end
    drive_cycle("val3_e2", 3);
    total += 3;
    if (bus0.AN !== 2'b01) begin bad++; $display("FAIL val3 AN got %b want 01", bus0.AN); end
    if (bus0.SEG !== 7'h4F) begin bad++; $display("FAIL val3 SEG got %h want 4F", bus0.SEG); end
    if (bus0.STUCK !== 1'b0) begin bad++; $display("FAIL val3 STUCK got %b want 0", bus0.STUCK); end
  endtask

  task automatic test_value13();
    int tens_seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle("val13", 13);
      if (bus0.AN == 2'b10) tens_seen++;
    end
    total++;
    if (tens_seen == 0) begin bad++; $display("FAIL val13 tens_digit got %0d want >0", tens_seen); end
  endtask

  task automatic test_blank7();
    int blank_seen = 0;
    for (int i = 0; i < 2 * DIVS[0] + 2; i++) begin
      drive_cycle("blank7", 7);
      if (bus0.AN == 2'b00 && bus0.SEG == 7'h00) blank_seen++;
    end
    total++;
    if (blank_seen == 0) begin bad++; $display("FAIL blank7 blank_cycles got %0d want >0", blank_seen); end
  endtask

  task automatic test_stall();
    drive_cycle("stall_pre", 4);
    drive_cycle("stall_chg", 5);
    drive_cycle("stall_eq1", 5);
    drive_cycle("stall_eq2", 5);
    total++;
    if (bus0.STUCK !== 1'b0) begin bad++; $display("FAIL stall_early STUCK got %b want 0", bus0.STUCK); end
    drive_cycle("stall_eq3", 5);
    total++;
    if (bus0.STUCK !== 1'b1) begin bad++; $display("FAIL stall_rise STUCK got %b want 1", bus0.STUCK); end
    drive_cycle("stall_eq4", 5);
    drive_cycle("stall_new", 6);
    total += 2;
    if (bus0.STUCK !== 1'b0) begin bad++; $display("FAIL stall_fall STUCK got %b want 0", bus0.STUCK); end
    if (bus0.CHG !== 1'b1) begin bad++; $display("FAIL stall_fall CHG got %b want 1", bus0.CHG); end
  endtask

  task automatic test_counter_seq();
    int seq [5] = '{3, 9, 10, 15, 0};
    for (int i = 0; i < 5; i++) begin
      drive_cycle("cnt_seq", seq[i]);
      total++;
      if (bus1.CHG !== 1'b1) begin bad++; $display("FAIL cnt_seq CHG got %b want 1", bus1.CHG); end
    end
  endtask

  task automatic test_random();
    int val = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(9, 0) >= 4) val = int'($urandom_range(15, 0));
      drive_cycle("random", val);
    end
  endtask

  task automatic test_reset_tens();
    int guard = 0;
    drive_cycle("rst_tens", 12);
    while (bus0.AN !== 2'b10 && guard < 20) begin
      drive_cycle("rst_tens", 12);
      guard++;
    end
    total++;
    if (bus0.AN !== 2'b10) begin bad++; $display("FAIL rst_tens_wait AN got %b want 10", bus0.AN); end
    async_reset("rst_tens_async");
    drive_cycle("rst_tens_first", 12);
    total += 2;
    if (bus0.AN !== 2'b01) begin bad++; $display("FAIL rst_tens_first AN got %b want 01", bus0.AN); end
    if (bus0.SEG !== 7'h3F) begin bad++; $display("FAIL rst_tens_first SEG got %h want 3F", bus0.SEG); end
    drive_cycle("rst_tens_next", 12);
  endtask

  initial begin
    bus0.I = 4'd0;
    bus1.I = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_value3();
    test_value13();
    test_blank7();
    test_stall();
    test_counter_seq();
    test_random();
    test_reset_tens();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_display_stage.md
# counter_display_stage

Downstream consumer of the arbitrary-sequence counter's decoded 4-bit value `I`. Registers the value every clock, detects changes and stalls, and drives a two-digit multiplexed 7-segment display showing the value 0..15 in decimal, with leading-zero suppression on the tens digit. It sits between the counter and the board display and runs on the counter's clock.

## Interface
- `DIV`, default 4: clock cycles each digit stays lit before the scan advances. Legal range is ≥1.
- `STALL`, default 3: number of consecutive clock edges with an unchanged input that raises `STUCK`. Legal range is ≥1.

Ports:
- `C`  in  1: clock, rising edge; same clock as the counter stage.
- `R`  in  1: reset, asynchronous, active-high.
- `I`  in  4: decoded counter value, unsigned 0..15.
- `V`  out 4: registered copy of `I`.
- `CHG`  out 1: one-cycle pulse meaning the value changed.
- `STUCK`  out 1: level meaning the value has not changed for `STALL` edges.
- `SEG`  out 7: segment drive, active-high. `SEG[0]`=a through `SEG[6]`=g.
- `AN`  out 2: digit enable, one-hot or all-zero. `AN[0]`=units, `AN[1]`=tens.

## Operation
- **Reset.** While `R`=1, asynchronously: `V`=0, `CHG`=0, `STUCK`=0, stall count `SC`=0, divider `DC`=0, digit select `DS`=0, `SEG`=0, `AN`=00. All registers hold while `R`=1.
- **Capture.** Each rising edge of `C`: `V`<=`I`, and `CHG`<=(`I`!=`V`old).
- **Stall count.**
  - If `I`==`V`old, `SC` increments, saturating at `STALL`. Otherwise `SC`<=0.
  - `STUCK`<=(`SC`next==`STALL`).
  - `STUCK` stays high until the first edge where `I` differs.
  - `SC` width is ceil(log2(`STALL`+1)).
- **Decimal split** (combinational, from `V`):
  - `T` = (`V`≥10).
  - `U` = `T` ? `V`−10 : `V`. `U` is always 0..9.
- **Scan.**
  - `DC` counts 0..`DIV`−1 and wraps to 0.
  - On the edge where `DC`==`DIV`−1, `DS` toggles.
  - With `DIV`=1, `DS` toggles every edge.
- **Output register** (registered each edge from the current `V` and `DS`, i.e. `V`/`DS` before this edge updates):
  - `DS`=0: `AN`<=01, `SEG`<=code(`U`).
  - `DS`=1 and `T`=1: `AN`<=10, `SEG`<=code(1)=0x06.
  - `DS`=1 and `T`=0: leading-zero blank, `AN`<=00, `SEG`<=0x00.
- **Segment codes** (hex, bit0=a): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Codes for values ≥10 are never used.
- **Input validity.** `I` is sampled only at edges; X/Z on `I` is not handled.

## Timing
- Latency from `I` sampled at edge n:
  - `V` and `CHG` are valid after edge n.
  - `SEG`/`AN` reflect that value after edge n+1, provided `DS` selects a digit.
- `CHG` is high for exactly one cycle per differing sample. It stays high on consecutive cycles if the input changes every cycle, which is the normal case for the counter.
- `STUCK` rises after the `STALL`th consecutive equal sample.
- A full display refresh (units + tens) takes 2·`DIV` cycles.
- **First edge after reset release.**
  - The `V`=0 comparison applies; an `I` of 0 counts as unchanged.
  - The output register presents units (`DS`=0) with `V` still 0, so `AN`=01, `SEG`=0x3F.
  - Captured `I` appears on `SEG`/`AN` one edge later (n+1).
- **Reset mid-scan.** `DC`/`DS` restart at 0; the first edge after release presents units.
- **Simultaneous change and scan toggle.** Capture and toggle are independent. The output register takes `V`/`DS` from before the edge.
- No handshake: the block accepts a new value every cycle and never back-pressures the counter.

## Test plan
1. **Reset and value 3.** Assert `R` mid-cycle, release, drive `I`=3 for 1 edge.
   - `V`=3 and `CHG`=1 after edge 1.
   - `AN`=01 and `SEG`=0x4F after edge 2.
   - `STUCK`=0.
2. **Value 13, `DIV`=4.** Hold `I`=13 for 10 edges.
   - `AN` alternates 01/10 every 4 cycles.
   - `SEG`=0x4F with units, 0x06 with tens.
3. **Value 7, leading-zero blank.** Hold `I`=7 over one full scan.
   - During `DS`=0: `AN`=01, `SEG`=0x07.
   - During `DS`=1: `AN`=00, `SEG`=0x00.
4. **Stall, `STALL`=3.**
   - Hold `I`=5 for 4 edges after a change: `STUCK` rises after the third equal sample.
   - Change to 6: `STUCK` falls and `CHG`=1 after that edge.
5. **Counter-like sequence, `DIV`=1.** Drive 3,9,10,15,0 on consecutive edges.
   - `CHG` stays 1 on every edge.
   - `DS` toggles every edge.
   - `SEG`/`AN` sequence is derived per the output rule, delayed one edge.
6. **Reset during tens display.** Assert `R` asynchronously while `AN`=10.
   - `SEG`=0 and `AN`=00 immediately, without waiting for a clock edge.
   - After release, the first edge shows units.
